// File: rtl/avmm_timer_pkg.sv
// Register map, control-word layout and FSM encodings shared by the
// interval-timer Avalon-MM master.
package avmm_timer_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam logic [15:0] CTL_STOP_WORD = 16'h0008;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RUN    = 4'd1;
  localparam logic [3:0] S_W_STOP = 4'd2;
  localparam logic [3:0] S_W_PL   = 4'd3;
  localparam logic [3:0] S_W_PH   = 4'd4;
  localparam logic [3:0] S_W_CTL  = 4'd5;
  localparam logic [3:0] S_GUARD  = 4'd6;
  localparam logic [3:0] S_W_HALT = 4'd7;
  localparam logic [3:0] S_W_CLR  = 4'd8;
  localparam logic [3:0] S_W_SNAP = 4'd9;
  localparam logic [3:0] S_R_SL   = 4'd10;
  localparam logic [3:0] S_R_SH   = 4'd11;
  localparam logic [3:0] S_R_CAP  = 4'd12;

  // START with the stored mode bits; STOP stays clear
  function automatic logic [15:0] ctl_start_word(input logic cont, input logic ito);
    logic [15:0] w;
    w = 16'h0000;
    w[CTL_START] = 1'b1;
    w[CTL_CONT]  = cont;
    w[CTL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/avmm_timer_master.sv
// Avalon-MM initiator that programs, services and snapshots an interval-timer
// slave, exposing a request/pulse interface to fabric logic.
module avmm_timer_master
  import avmm_timer_pkg::*;
#(
  parameter int TICK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  input  logic                  cfg_irq_en,
  input  logic                  stop_req,
  input  logic                  snap_req,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  busy,
  output logic [2:0]            av_address,
  output logic                  av_chipselect,
  output logic                  av_write_n,
  output logic [15:0]           av_writedata,
  input  logic [15:0]           av_readdata,
  input  logic                  av_irq
);

  logic [3:0]  state, nstate;
  logic        stop_pend, snap_pend, cfg_pend, running;
  logic        n_stop_pend, n_snap_pend, n_cfg_pend, n_running;
  logic [31:0] per_q;
  logic        cont_q, irq_en_q;
  logic [15:0] snap_lo;

  logic        stop_any, snap_any, cfg_acc, timeout, n_rest;
  logic        n_cs, n_wn;
  logic [2:0]  n_addr;
  logic [15:0] n_wd;

  // Same-cycle pulses count as pending so a stop beats a coincident timeout
  assign stop_any = stop_pend | stop_req;
  assign snap_any = snap_pend | snap_req;
  assign cfg_acc  = cfg_valid & cfg_ready;
  assign timeout  = (state == S_RUN) && (irq_en_q ? av_irq : av_readdata[0]);

  always_comb begin
    nstate      = state;
    n_stop_pend = stop_any;
    n_snap_pend = snap_any;
    n_cfg_pend  = cfg_pend | cfg_acc;
    n_running   = running;
    case (state)
      S_IDLE, S_RUN: begin
        if (stop_any) begin
          nstate      = S_W_HALT;
          n_stop_pend = 1'b0;
        end else if (n_cfg_pend) begin
          nstate     = S_W_STOP;
          n_cfg_pend = 1'b0;
        end else if (timeout) begin
          nstate = S_W_CLR;
        end else if (snap_any) begin
          nstate      = S_W_SNAP;
          n_snap_pend = 1'b0;
        end
      end
      S_W_STOP: nstate = S_W_PL;
      S_W_PL:   nstate = S_W_PH;
      S_W_PH:   nstate = S_W_CTL;
      S_W_CTL: begin
        nstate    = S_GUARD;
        n_running = 1'b1;
      end
      S_GUARD:  nstate = S_RUN;
      S_W_HALT: begin
        nstate    = S_IDLE;
        n_running = 1'b0;
      end
      S_W_CLR:  nstate = S_GUARD;
      S_W_SNAP: nstate = S_R_SL;
      S_R_SL:   nstate = S_R_SH;
      S_R_SH:   nstate = S_R_CAP;
      S_R_CAP:  nstate = running ? S_GUARD : S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered values line
  // up with the state they belong to.
  always_comb begin
    n_cs   = 1'b1;
    n_wn   = 1'b1;
    n_addr = TMR_STATUS;
    n_wd   = 16'h0000;
    case (nstate)
      S_W_STOP, S_W_HALT: begin n_wn = 1'b0; n_addr = TMR_CONTROL; n_wd = CTL_STOP_WORD; end
      S_W_PL:   begin n_wn = 1'b0; n_addr = TMR_PERIODL; n_wd = per_q[15:0]; end
      S_W_PH:   begin n_wn = 1'b0; n_addr = TMR_PERIODH; n_wd = per_q[31:16]; end
      S_W_CTL:  begin n_wn = 1'b0; n_addr = TMR_CONTROL; n_wd = ctl_start_word(cont_q, irq_en_q); end
      S_W_CLR:  n_wn = 1'b0;
      S_W_SNAP: begin n_wn = 1'b0; n_addr = TMR_SNAPL; end
      S_R_SL:   n_addr = TMR_SNAPL;
      S_R_SH:   n_addr = TMR_SNAPH;
      S_RUN, S_GUARD: n_addr = TMR_STATUS;
      default:  n_cs = 1'b0;
    endcase
  end

  assign n_rest = (nstate == S_IDLE) || (nstate == S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      stop_pend     <= 1'b0;
      snap_pend     <= 1'b0;
      cfg_pend      <= 1'b0;
      running       <= 1'b0;
      per_q         <= '0;
      cont_q        <= 1'b0;
      irq_en_q      <= 1'b0;
      snap_lo       <= '0;
      av_address    <= '0;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_writedata  <= '0;
      cfg_ready     <= 1'b0;
      busy          <= 1'b0;
      tick          <= 1'b0;
      tick_count    <= '0;
      snap_valid    <= 1'b0;
      snap_value    <= '0;
    end else begin
      state         <= nstate;
      stop_pend     <= n_stop_pend;
      snap_pend     <= n_snap_pend;
      cfg_pend      <= n_cfg_pend;
      running       <= n_running;
      if (cfg_acc) begin
        per_q    <= cfg_period;
        cont_q   <= cfg_continuous;
        irq_en_q <= cfg_irq_en;
      end
      av_address    <= n_addr;
      av_chipselect <= n_cs;
      av_write_n    <= n_wn;
      av_writedata  <= n_wd;
      cfg_ready     <= n_rest && !n_stop_pend && !n_cfg_pend;
      busy          <= !n_rest;
      tick          <= (nstate == S_W_CLR);
      if (nstate == S_W_CLR) tick_count <= tick_count + TICK_CNT_W'(1);
      // readdata trails the address by one cycle
      if (state == S_R_SH) snap_lo <= av_readdata;
      if (state == S_R_CAP) snap_value <= {av_readdata, snap_lo};
      snap_valid    <= (state == S_R_CAP);
    end
  end

endmodule

// File: doc/avmm_timer_master.md
Name: avmm_timer_master

Overview:
- Hardware Avalon-MM initiator that drives the 16-bit-data, 3-bit-address interval-timer slave, so timers can run without Nios II software.
- Programs the period, starts and stops the timer, and services timeouts by IRQ or by status polling.
- Clears the timeout status and performs snapshot reads.
- Presents a simple request/pulse interface to fabric logic such as the DSO trigger and sample-rate control.

Parameters:
- TICK_CNT_W, 16, width of the timeout-event counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- cfg_valid  in  1  configure request, held until accepted
- cfg_ready  out  1  cfg accepted when cfg_valid&&cfg_ready
- cfg_period  in  32  period value to load (timer counts period..0)
- cfg_continuous  in  1  continuous-mode bit
- cfg_irq_en  in  1  1 = detect timeout via irq; 0 = poll status bit 0
- stop_req  in  1  single-cycle pulse, stop timer
- snap_req  in  1  single-cycle pulse, request counter snapshot
- snap_valid  out  1  one-cycle pulse, snap_value updated
- snap_value  out  32  captured snapshot {hi,lo}
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_CNT_W  timeout count, wraps
- busy  out  1  high in any state other than IDLE or RUN
- av_address  out  3  slave register address
- av_chipselect  out  1  slave select
- av_write_n  out  1  active-low write
- av_writedata  out  16  write data
- av_readdata  in  16  slave read data; registered, valid the cycle after the address is presented
- av_irq  in  1  timer interrupt

Interface (already decided): one clock `clk`; reset `reset_n` is asynchronous, active-low.

Behaviour:
- Slave map:
  - 0: status (wr = clear TO, rd bit0 TO / bit1 RUN)
  - 1: control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP)
  - 2: period_l, 3: period_h
  - 4: snap_l, 5: snap_h (wr = latch)
- No waitrequest: every write completes in 1 cycle.
- Reset values:
  - av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
  - cfg_ready=0, snap_valid=0, snap_value=0, tick=0, tick_count=0, busy=0.
  - FSM=IDLE; pending flags cleared; stored cfg bits 0.
- All outputs are registered.
- Bus values by state:
  - Write states: chipselect=1, write_n=0.
  - Read states: chipselect=1, write_n=1.
  - IDLE: chipselect=0.
  - RUN: continuous read of address 0.
- snap_req and stop_req set sticky pending flags. Each flag clears when its sequence starts.
- Arbitration in IDLE/RUN: stop > cfg > timeout > snap.
- cfg_ready=1 only in IDLE/RUN when no stop is pending.
- cfg sequence: W_STOP(a1, 0x0008) -> W_PL(a2, period[15:0]) -> W_PH(a3, period[31:16]) -> W_CTL(a1, {12'b0, 0, 1, cont, irq_en}) -> GUARD -> RUN.
  - cfg fields are latched on acceptance.
  - Exactly 4 write cycles, one per register.
- stop sequence: W_HALT(a1, 0x0008) -> IDLE. An unstarted pending cfg remains pending.
- Timeout detection in RUN:
  - irq_en=1: av_irq=1.
  - irq_en=0: av_readdata[0]=1.
- Timeout service: W_CLR(a0, 0x0000) -> GUARD -> RUN.
  - tick pulses in the W_CLR cycle.
  - tick_count increments modulo 2^TICK_CNT_W.
- GUARD: one cycle reading address 0. Detection is ignored there, masking stale irq/readdata after a clear or start.
- snap sequence: W_SNAP(a4) -> R_SL(rd a4) -> R_SH(rd a5, capture lo) -> R_CAP(idle bus, capture hi) -> return.
  - snap_valid pulses 1 cycle after R_CAP.
  - Return target is RUN via GUARD if running, else IDLE.
- One-shot mode: after a timeout is serviced, the master stays in RUN. The slave has stopped itself, so no further ticks occur.
- Requests during busy:
  - stop_req and snap_req are recorded and serviced at the next IDLE/RUN.
  - A repeat pulse while already pending is merged.
  - cfg waits for cfg_ready.
- reset_n asserted mid-sequence: FSM aborts to IDLE immediately and outputs return to reset values. A partial slave write sequence is left as-is.

Decomposition:
- Package avmm_timer_pkg:
  - Register addresses TMR_STATUS=0, TMR_CONTROL=1, TMR_PERIODL=2, TMR_PERIODH=3, TMR_SNAPL=4, TMR_SNAPH=5.
  - Control bit positions ITO/CONT/START/STOP.
  - CTL_STOP_WORD=16'h0008.
  - State enum.
- No sub-module: single FSM with datapath registers.

Test Plan:
- Reset, then cfg_period=0x0001869F, cont=1, irq_en=1 -> writes in order:
  - a1=0x0008
  - a2=0x869F
  - a3=0x0001
  - a1=0x0007

  Then RUN; with the slave model attached, tick each 100000 cycles; tick_count reaches 3 after 3 periods.
- cfg_period=9, cont=0, irq_en=0 (polling) -> exactly one tick; W_CLR a0 write observed; tick_count stays 1 thereafter.
- In RUN with period 1000, snap_req -> W_SNAP a4, reads a4/a5; snap_valid pulse; snap_value equals the slave counter at the W_SNAP edge, within 0..1000.
- stop_req asserted in the same cycle as av_irq -> W_HALT a1=0x0008 first, then IDLE; the timeout is not serviced and tick stays 0.
- snap_req during the cfg W_PL state -> the snapshot runs after W_CTL/GUARD; exactly one snap_valid.
- With TICK_CNT_W=2, 5 timeouts -> tick_count=1 (wrap). reset_n pulsed low during W_PH -> all bus outputs at reset values within the same cycle.
